uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with first-word-fall-through receive FIFO
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        serial_in,
  output logic [DATA_BITS-1:0]        data_out,
  output logic                        data_out_perr,
  output logic                        data_out_ferr,
  output logic                        data_out_valid,
  input  logic                        data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  input  logic                        overrun_clear
);
  localparam int P  = CLOCK_FREQ / BAUD_RATE;
  localparam int H  = P / 2;
  localparam int CW = $clog2(P + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t               state, state_n;
  logic                 sync1, rx_s;
  logic [1:0]           fill;
  logic                 armed;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 pbit, pbit_n;
  logic                 ferr, ferr_n;
  logic                 wr, wr_n;
  logic                 expire;
  logic                 perr_w;

  // armed only goes high once the synchronizer carries real line samples and sees high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      sync1 <= serial_in;
      rx_s  <= sync1;
      fill  <= {fill[0], 1'b1};
      if (fill[1] && rx_s && state == S_IDLE)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      pbit  <= 1'b0;
      ferr  <= 1'b0;
      wr    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      pbit  <= pbit_n;
      ferr  <= ferr_n;
      wr    <= wr_n;
    end
  end

  assign expire = (cnt == CW'(1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    pbit_n  = pbit;
    ferr_n  = ferr;
    wr_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (armed && !rx_s) begin
          state_n = S_START;
          cnt_n   = CW'(H);
        end
      end
      S_START: begin
        if (!expire) begin
          cnt_n = cnt - CW'(1);
        end else if (rx_s) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_DATA;
          cnt_n   = CW'(P);
          idx_n   = '0;
          ferr_n  = 1'b0;
        end
      end
      S_DATA: begin
        if (!expire) begin
          cnt_n = cnt - CW'(1);
        end else begin
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          cnt_n   = CW'(P);
          if (idx == 3'(DATA_BITS - 1)) begin
            idx_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (!expire) begin
          cnt_n = cnt - CW'(1);
        end else begin
          pbit_n  = rx_s;
          cnt_n   = CW'(P);
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (!expire) begin
          cnt_n = cnt - CW'(1);
        end else begin
          if (!rx_s)
            ferr_n = 1'b1;
          if (idx == 3'(STOP_BITS - 1)) begin
            wr_n    = 1'b1;
            idx_n   = '0;
            state_n = rx_s ? S_IDLE : S_WAIT_IDLE;
          end else begin
            idx_n = idx + 3'd1;
            cnt_n = CW'(P);
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    perr_w = 1'b0;
    if (PARITY != 0)
      perr_w = ((^shift) ^ pbit) != (PARITY == 1);
  end

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, push, drop;
  logic [WW-1:0] head;

  assign full           = (count == (AW+1)'(FIFO_DEPTH));
  assign data_out_valid = (count != '0);
  assign pop            = data_out_valid && data_out_ready;
  assign push           = wr && (!full || pop);
  assign drop           = wr && full && !pop;
  assign head           = mem[rd_ptr];
  assign data_out       = data_out_valid ? head[DATA_BITS-1:0] : '0;
  assign data_out_perr  = data_out_valid & head[DATA_BITS];
  assign data_out_ferr  = data_out_valid & head[DATA_BITS+1];
  assign fifo_count     = count;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {ferr, perr_w, shift};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // a drop in the same cycle as a clear leaves the flag set
      if (drop)
        overrun <= 1'b1;
      else if (overrun_clear)
        overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - bench for uart_rx_fifo across four parameter sets
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int NI = 4;
  localparam int QD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       line  [NI];
  logic       rdy   [NI];
  logic       oclr  [NI];
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic       perr_o [NI];
  logic       ferr_o [NI];
  logic       valid_o[NI];
  logic       ovr_o  [NI];
  logic [3:0] cnt_o  [NI];

  uart_rx_fifo u0 (
    .clk(clk), .rst(rst), .serial_in(line[0]), .data_out(d0),
    .data_out_perr(perr_o[0]), .data_out_ferr(ferr_o[0]), .data_out_valid(valid_o[0]),
    .data_out_ready(rdy[0]), .fifo_count(cnt_o[0]), .overrun(ovr_o[0]), .overrun_clear(oclr[0]));
  uart_rx_fifo #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000)) u1 (
    .clk(clk), .rst(rst), .serial_in(line[1]), .data_out(d1),
    .data_out_perr(perr_o[1]), .data_out_ferr(ferr_o[1]), .data_out_valid(valid_o[1]),
    .data_out_ready(rdy[1]), .fifo_count(cnt_o[1]), .overrun(ovr_o[1]), .overrun_clear(oclr[1]));
  uart_rx_fifo #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .PARITY(2)) u2 (
    .clk(clk), .rst(rst), .serial_in(line[2]), .data_out(d2),
    .data_out_perr(perr_o[2]), .data_out_ferr(ferr_o[2]), .data_out_valid(valid_o[2]),
    .data_out_ready(rdy[2]), .fifo_count(cnt_o[2]), .overrun(ovr_o[2]), .overrun_clear(oclr[2]));
  uart_rx_fifo #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .serial_in(line[3]), .data_out(d3),
    .data_out_perr(perr_o[3]), .data_out_ferr(ferr_o[3]), .data_out_valid(valid_o[3]),
    .data_out_ready(rdy[3]), .fifo_count(cnt_o[3]), .overrun(ovr_o[3]), .overrun_clear(oclr[3]));

  // model: per-instance queue of {ferr, perr, data}, sticky overrun, "frame in flight" flag
  logic [9:0] mq [NI][$];
  bit         ovr_e [NI];
  bit         busy  [NI];
  bit         rnd   [NI];
  int         checks, errors, cyc, lat, lat_start;
  bit         lat_arm;

  function automatic int per(int i);   return (i == 0) ? 434 : 16; endfunction
  function automatic int nbits(int i); return (i == 3) ? 7 : 8; endfunction
  function automatic int pmode(int i); return (i == 2) ? 2 : ((i == 3) ? 1 : 0); endfunction
  function automatic int nstop(int i); return (i == 3) ? 2 : 1; endfunction
  function automatic logic [7:0] dget(int i);
    case (i)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      default: return {1'b0, d3};
    endcase
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h required %0h at cycle %0d", nm, i, act, exp, cyc);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      logic [9:0] h;
      if (!busy[i]) begin
        h = (mq[i].size() > 0) ? mq[i][0] : 10'd0;
        chk("valid", i, 32'(valid_o[i]), 32'(mq[i].size() > 0));
        chk("data", i, 32'(dget(i)), 32'(h[7:0]));
        chk("perr", i, 32'(perr_o[i]), 32'(h[8]));
        chk("ferr", i, 32'(ferr_o[i]), 32'(h[9]));
        chk("count", i, 32'(cnt_o[i]), 32'(mq[i].size()));
        chk("overrun", i, 32'(ovr_o[i]), 32'(ovr_e[i]));
      end
    end
  endtask

  task automatic tick();
    bit pop [NI];
    bit clr [NI];
    for (int i = 0; i < NI; i++) begin
      if (rnd[i]) begin
        rdy[i]  = ($urandom_range(0, 3) == 0) &&
                  (!busy[i] || (mq[i].size() > 0 && mq[i].size() < QD));
        oclr[i] = !busy[i] && ($urandom_range(0, 15) == 0);
      end
      pop[i] = rdy[i] && (mq[i].size() > 0);
      clr[i] = oclr[i];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (pop[i]) void'(mq[i].pop_front());
      if (clr[i]) ovr_e[i] = 1'b0;
    end
    if (lat_arm && lat < 0 && valid_o[0] === 1'b1)
      lat = cyc - lat_start;
    check_all();
  endtask

  task automatic model_push(input int i, input logic [9:0] w);
    if (mq[i].size() >= QD) ovr_e[i] = 1'b1;
    else mq[i].push_back(w);
  endtask

  task automatic send_frame(input int i, input logic [7:0] d, input logic pb, input logic [1:0] st);
    logic [7:0] dm;
    logic       pe, fe;
    dm = (nbits(i) == 7) ? (d & 8'h7f) : d;
    busy[i] = 1'b1;
    if (i == 0) begin lat_start = cyc; lat = -1; end
    line[i] = 1'b0;
    repeat (per(i)) tick();
    for (int k = 0; k < nbits(i); k++) begin
      line[i] = dm[k];
      repeat (per(i)) tick();
    end
    if (pmode(i) != 0) begin
      line[i] = pb;
      repeat (per(i)) tick();
    end
    fe = 1'b0;
    for (int k = 0; k < nstop(i); k++) begin
      line[i] = st[k];
      if (!st[k]) fe = 1'b1;
      repeat (per(i)) tick();
    end
    pe = (pmode(i) == 0) ? 1'b0 : (((^dm) ^ pb) != (pmode(i) == 1));
    model_push(i, {fe, pe, dm});
    line[i] = 1'b1;
    busy[i] = 1'b0;
  endtask

  task automatic pop_one(input int i);
    rdy[i] = 1'b1;
    tick();
    rdy[i] = 1'b0;
  endtask

  initial begin
    int mid;
    checks = 0; errors = 0; cyc = 0; lat = -1; lat_start = 0; lat_arm = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      line[i] = 1'b1; rdy[i] = 1'b0; oclr[i] = 1'b0;
      busy[i] = 1'b0; rnd[i] = 1'b0; ovr_e[i] = 1'b0;
    end
    repeat (3) tick();
    chk("rst_valid", 0, 32'(valid_o[0]), 32'd0);
    chk("rst_count", 1, 32'(cnt_o[1]), 32'd0);
    rst = 1'b1;
    repeat (5) tick();

    // default configuration: 0x61 and valid latency after the stop-bit midpoint
    lat_arm = 1'b1;
    send_frame(0, 8'h61, 1'b0, 2'b11);
    lat_arm = 1'b0;
    mid = 434 / 2 + 9 * 434;
    chk("latency_window", 0, 32'(lat >= mid && lat <= mid + 5), 32'd1);
    chk("d61_data", 0, 32'(d0), 32'h61);
    chk("d61_ferr", 0, 32'(ferr_o[0]), 32'd0);
    pop_one(0);
    line[0] = 1'b0;
    repeat (100) tick();
    line[0] = 1'b1;
    repeat (400) tick();
    chk("false_start_count", 0, 32'(cnt_o[0]), 32'd0);
    send_frame(0, 8'($urandom), 1'b0, 2'b11);
    repeat (10) tick();
    pop_one(0);

    // ten bytes into an 8-deep FIFO with no consumer
    for (int k = 0; k < 10; k++) send_frame(1, 8'(8'h30 + k), 1'b0, 2'b11);
    repeat (10) tick();
    chk("ovr_count", 1, 32'(cnt_o[1]), 32'd8);
    chk("ovr_flag", 1, 32'(ovr_o[1]), 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("ovr_pop_order", 1, 32'(d1), 32'(8'h30 + k));
      pop_one(1);
    end
    chk("drained", 1, 32'(cnt_o[1]), 32'd0);
    rdy[1] = 1'b1;
    repeat (3) tick();
    rdy[1] = 1'b0;
    oclr[1] = 1'b1;
    tick();
    oclr[1] = 1'b0;
    chk("ovr_cleared", 1, 32'(ovr_o[1]), 32'd0);

    // break: one 0x00 word with framing error, then silence until the line is high
    busy[1] = 1'b1;
    line[1] = 1'b0;
    repeat (20 * 16) tick();
    model_push(1, {1'b1, 1'b0, 8'h00});
    line[1] = 1'b1;
    busy[1] = 1'b0;
    repeat (40) tick();
    chk("break_count", 1, 32'(cnt_o[1]), 32'd1);
    chk("break_ferr", 1, 32'(ferr_o[1]), 32'd1);
    pop_one(1);
    line[1] = 1'b0;
    repeat (5) tick();
    line[1] = 1'b1;
    repeat (40) tick();
    send_frame(1, 8'hC3, 1'b0, 2'b11);
    repeat (4) tick();
    chk("after_glitch", 1, 32'(d1), 32'hC3);
    pop_one(1);

    // even parity: 0xA5 has four ones
    send_frame(2, 8'hA5, 1'b1, 2'b11);
    repeat (4) tick();
    chk("even_par_bad", 2, 32'(perr_o[2]), 32'd1);
    pop_one(2);
    send_frame(2, 8'hA5, 1'b0, 2'b11);
    repeat (4) tick();
    chk("even_par_ok", 2, 32'(perr_o[2]), 32'd0);
    pop_one(2);

    // 7 data bits, odd parity, second stop bit low
    send_frame(3, 8'h55, 1'b1, 2'b01);
    repeat (4) tick();
    chk("stop2_ferr", 3, 32'(ferr_o[3]), 32'd1);
    chk("stop2_perr", 3, 32'(perr_o[3]), 32'd0);
    chk("stop2_data", 3, 32'(d3), 32'h55);
    pop_one(3);

    for (int i = 1; i < NI; i++) begin
      rnd[i] = 1'b1;
      repeat (25) begin
        send_frame(i, 8'($urandom), 1'($urandom),
                   ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11);
        repeat ($urandom_range(2, 2 * per(i))) tick();
      end
      rnd[i] = 1'b0;
      oclr[i] = 1'b0;
      rdy[i] = 1'b1;
      repeat (12) tick();
      rdy[i] = 1'b0;
    end

    // reset in the middle of data bit 4 of 0x0F, line held low through release
    send_frame(1, 8'h77, 1'b0, 2'b11);
    busy[1] = 1'b1;
    line[1] = 1'b0;
    repeat (16) tick();
    line[1] = 1'b1;
    repeat (4 * 16) tick();
    line[1] = 1'b0;
    repeat (8) tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      ovr_e[i] = 1'b0;
    end
    busy[1] = 1'b0;
    chk("async_rst_valid", 1, 32'(valid_o[1]), 32'd0);
    chk("async_rst_data", 1, 32'(d1), 32'd0);
    check_all();
    repeat (3) tick();
    rst = 1'b1;
    repeat (3 * 16) tick();
    line[1] = 1'b1;
    repeat (32) tick();
    send_frame(1, 8'h5A, 1'b0, 2'b11);
    repeat (4) tick();
    chk("post_rst_count", 1, 32'(cnt_o[1]), 32'd1);
    chk("post_rst_data", 1, 32'(d1), 32'h5A);
    pop_one(1);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
